// File: rtl/execute_stage_pipe_if.sv
// Execute-stage bundle: E-register inputs, pipeline controls,
// forwarding tap, M-register outputs and condition codes.
// master = upstream/control side, slave = execute stage.
interface execute_stage_pipe_if #(
    parameter int W = 64
);
    logic [2:0]   e_stat;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] e_valC;
    logic [W-1:0] e_valA;
    logic [W-1:0] e_valB;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         set_cc_en;
    logic         m_stall;
    logic         m_bubble;
    logic         e_kill;
    logic [W-1:0] fwd_valE;
    logic [3:0]   fwd_dstE;
    logic         ex_busy;
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;
    logic         ZF;
    logic         SF;
    logic         OF;

    modport master (
        output e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB,
        output e_dstE, e_dstM, set_cc_en, m_stall, m_bubble, e_kill,
        input  fwd_valE, fwd_dstE, ex_busy,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        input  ZF, SF, OF
    );

    modport slave (
        input  e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB,
        input  e_dstE, e_dstM, set_cc_en, m_stall, m_bubble, e_kill,
        output fwd_valE, fwd_dstE, ex_busy,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
        output ZF, SF, OF
    );
endinterface

// File: rtl/execute_stage_pipe.sv
// Y86-64 PIPE execute stage: ALU, CC register, cond evaluation, E->M register.
// Ports: clk, rst (async high), bus (execute_stage_pipe_if.slave).
// Optional macro EXEC_MUL_EN adds a shift-add mulq (OPq ifun 4).
module execute_stage_pipe #(
    parameter int W        = 64,
    parameter int STK_STEP = 8
) (
    input  logic                clk,
    input  logic                rst,
    execute_stage_pipe_if.slave bus
);
    localparam logic [2:0] S_AOK  = 3'd1;
    localparam logic [2:0] S_INS  = 3'd4;
    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_CMOV = 4'h2;
    localparam logic [3:0] I_IRMV = 4'h3;
    localparam logic [3:0] I_RMMV = 4'h4;
    localparam logic [3:0] I_MRMV = 4'h5;
    localparam logic [3:0] I_OPQ  = 4'h6;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] I_PUSH = 4'hA;
    localparam logic [3:0] I_POP  = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF;
`ifdef EXEC_MUL_EN
    localparam logic [3:0] MAX_OP = 4'd4;
`else
    localparam logic [3:0] MAX_OP = 4'd3;
`endif
    localparam logic [W-1:0] STEP = W'(STK_STEP);

    logic [W-1:0] w_alu;
    logic [W-1:0] w_valE;
    logic         w_of;
    logic         w_opq;
    logic         w_bad;
    logic         w_cmj;
    logic         w_cond;
    logic         w_cnd;
    logic [3:0]   w_dstE;
    logic [2:0]   w_stat;
    logic         w_cc_we;
    logic         w_mbub;

    logic         r_zf;
    logic         r_sf;
    logic         r_of;
    logic [2:0]   r_stat;
    logic [3:0]   r_icode;
    logic         r_cnd;
    logic [W-1:0] r_valE;
    logic [W-1:0] r_valA;
    logic [3:0]   r_dstE;
    logic [3:0]   r_dstM;

    assign w_opq  = bus.e_icode == I_OPQ;
    assign w_cmj  = (bus.e_icode == I_CMOV) || (bus.e_icode == I_JXX);
    assign w_bad  = (w_opq && bus.e_ifun > MAX_OP)
                  || (w_cmj && bus.e_ifun > 4'd6);
    assign w_stat = (bus.e_stat == S_AOK && w_bad) ? S_INS : bus.e_stat;

    // Overflow is judged on operand/result sign bits, W-bit wrap.
    always_comb begin
        w_alu = '0;
        w_of  = 1'b0;
        case (bus.e_icode)
            I_OPQ: begin
                case (bus.e_ifun)
                    4'd0: begin
                        w_alu = bus.e_valB + bus.e_valA;
                        w_of  = (bus.e_valA[W-1] == bus.e_valB[W-1])
                              && (w_alu[W-1] != bus.e_valA[W-1]);
                    end
                    4'd1: begin
                        w_alu = bus.e_valB - bus.e_valA;
                        w_of  = (bus.e_valA[W-1] != bus.e_valB[W-1])
                              && (w_alu[W-1] != bus.e_valB[W-1]);
                    end
                    4'd2:    w_alu = bus.e_valB & bus.e_valA;
                    4'd3:    w_alu = bus.e_valB ^ bus.e_valA;
                    default: w_alu = '0;
                endcase
            end
            I_IRMV:         w_alu = bus.e_valC;
            I_RMMV, I_MRMV: w_alu = bus.e_valB + bus.e_valC;
            I_CALL, I_PUSH: w_alu = bus.e_valB - STEP;
            I_RET, I_POP:   w_alu = bus.e_valB + STEP;
            I_CMOV:         w_alu = bus.e_valA;
            default:        w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (bus.e_ifun)
            4'd0:    w_cond = 1'b1;
            4'd1:    w_cond = (r_sf ^ r_of) | r_zf;
            4'd2:    w_cond = r_sf ^ r_of;
            4'd3:    w_cond = r_zf;
            4'd4:    w_cond = ~r_zf;
            4'd5:    w_cond = ~(r_sf ^ r_of);
            4'd6:    w_cond = ~(r_sf ^ r_of) & ~r_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd  = w_cmj ? w_cond : 1'b1;
    assign w_dstE = (bus.e_icode == I_CMOV && !w_cnd) ? R_NONE : bus.e_dstE;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} mul_st_e;
    localparam int CW = $clog2(W);

    mul_st_e      r_st;
    mul_st_e      w_st_nx;
    logic         w_start;
    logic         w_mulq;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_ma;
    logic [W-1:0] r_mb;
    logic [CW-1:0] r_cnt;

    assign w_mulq = w_opq && bus.e_ifun == 4'd4 && bus.e_stat == S_AOK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_st <= ST_IDLE;
        else     r_st <= w_st_nx;
    end

    // M receives bubbles while the product is being built; it only
    // captures the mulq in DONE, unless the op is killed.
    always_comb begin
        w_st_nx = r_st;
        w_start = 1'b0;
        w_mbub  = 1'b0;
        unique case (r_st)
            ST_IDLE: begin
                if (w_mulq) begin
                    w_start = 1'b1;
                    w_mbub  = 1'b1;
                    w_st_nx = ST_MUL;
                end
            end
            ST_MUL: begin
                w_mbub = 1'b1;
                if (bus.e_kill)                 w_st_nx = ST_IDLE;
                else if (r_cnt == CW'(W - 1))   w_st_nx = ST_DONE;
            end
            ST_DONE: begin
                if (bus.e_kill) begin
                    w_mbub  = 1'b1;
                    w_st_nx = ST_IDLE;
                end else if (!bus.m_stall) begin
                    w_st_nx = ST_IDLE;
                end
            end
            default: w_st_nx = ST_IDLE;
        endcase
    end

    // Shift-add: one multiplier bit per cycle, low W bits kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ma  <= '0;
            r_mb  <= '0;
            r_cnt <= '0;
        end else if (w_start) begin
            r_acc <= '0;
            r_ma  <= bus.e_valA;
            r_mb  <= bus.e_valB;
            r_cnt <= '0;
        end else if (r_st == ST_MUL) begin
            if (r_ma[0]) r_acc <= r_acc + r_mb;
            r_ma  <= r_ma >> 1;
            r_mb  <= r_mb << 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_valE      = (r_st == ST_DONE) ? r_acc : w_alu;
    assign bus.ex_busy = r_st == ST_MUL;
`else
    logic w_unused_kill;
    assign w_unused_kill = bus.e_kill;
    assign w_mbub        = 1'b0;
    assign w_valE        = w_alu;
    assign bus.ex_busy   = 1'b0;
`endif

    assign w_cc_we = w_opq && bus.set_cc_en && bus.e_stat == S_AOK
                   && !bus.m_stall && !w_bad && !w_mbub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_we) begin
            r_zf <= w_valE == '0;
            r_sf <= w_valE[W-1];
            r_of <= w_of;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat  <= S_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= R_NONE;
            r_dstM  <= R_NONE;
        end else if (bus.m_stall) begin
            r_stat  <= r_stat;
        end else if (bus.m_bubble || w_mbub) begin
            r_stat  <= S_AOK;
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_valE  <= '0;
            r_valA  <= '0;
            r_dstE  <= R_NONE;
            r_dstM  <= R_NONE;
        end else begin
            r_stat  <= w_stat;
            r_icode <= bus.e_icode;
            r_cnd   <= w_cnd;
            r_valE  <= w_valE;
            r_valA  <= bus.e_valA;
            r_dstE  <= w_dstE;
            r_dstM  <= bus.e_dstM;
        end
    end

    assign bus.fwd_valE = w_valE;
    assign bus.fwd_dstE = w_dstE;
    assign bus.M_stat   = r_stat;
    assign bus.M_icode  = r_icode;
    assign bus.M_cnd    = r_cnd;
    assign bus.M_valE   = r_valE;
    assign bus.M_valA   = r_valA;
    assign bus.M_dstE   = r_dstE;
    assign bus.M_dstM   = r_dstM;
    assign bus.ZF       = r_zf;
    assign bus.SF       = r_sf;
    assign bus.OF       = r_of;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Scoreboard bench for execute_stage_pipe: directed Y86 cases plus
// random instruction stream against a behavioural model.
module tb_execute_stage_pipe;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_pipe_if #(.W(W)) bus ();
    execute_stage_pipe #(.W(W), .STK_STEP(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0]   stat;
        logic [3:0]   icode;
        logic         cnd;
        logic [W-1:0] valE;
        logic [W-1:0] valA;
        logic [3:0]   dstE;
        logic [3:0]   dstM;
        logic         zf;
        logic         sf;
        logic         of;
    } mst_t;

    mst_t q[$];
    mst_t m;
    int   checks   = 0;
    int   failures = 0;

`ifdef EXEC_MUL_EN
    localparam int MAXOP = 4;
`else
    localparam int MAXOP = 3;
`endif

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic void reset_model();
        m.stat  = 3'd1;
        m.icode = 4'h1;
        m.cnd   = 1'b0;
        m.valE  = '0;
        m.valA  = '0;
        m.dstE  = 4'hF;
        m.dstM  = 4'hF;
        m.zf    = 1'b1;
        m.sf    = 1'b0;
        m.of    = 1'b0;
    endfunction

    function automatic void bubble_model();
        m.stat  = 3'd1;
        m.icode = 4'h1;
        m.cnd   = 1'b0;
        m.valE  = '0;
        m.valA  = '0;
        m.dstE  = 4'hF;
        m.dstM  = 4'hF;
    endfunction

    initial begin : mon
        mst_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("M_stat",  bus.M_stat,  e.stat);
                chk("M_icode", bus.M_icode, e.icode);
                chk("M_cnd",   bus.M_cnd,   e.cnd);
                chk("M_valE",  bus.M_valE,  e.valE);
                chk("M_valA",  bus.M_valA,  e.valA);
                chk("M_dstE",  bus.M_dstE,  e.dstE);
                chk("M_dstM",  bus.M_dstM,  e.dstM);
                chk("ZF", bus.ZF, e.zf);
                chk("SF", bus.SF, e.sf);
                chk("OF", bus.OF, e.of);
            end
        end
    end

    task automatic issue(input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [W-1:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic en, input logic stl, input logic bub);
        logic [W-1:0] v;
        logic [W:0]   sx;
        logic         o, bad, lt, eq, cd, we;
        logic [3:0]   d;
        @(negedge clk);
        bus.e_stat = st;   bus.e_icode = ic;  bus.e_ifun = fn;
        bus.e_valC = c;    bus.e_valA = a;    bus.e_valB = b;
        bus.e_dstE = de;   bus.e_dstM = dm;   bus.set_cc_en = en;
        bus.m_stall = stl; bus.m_bubble = bub; bus.e_kill = 1'b0;
        v = '0;
        o = 1'b0;
        case (ic)
            4'h6: begin
                if (fn == 0) begin
                    sx = {b[W-1], b} + {a[W-1], a};
                    v  = sx[W-1:0];
                    o  = sx[W] != sx[W-1];
                end else if (fn == 1) begin
                    sx = {b[W-1], b} - {a[W-1], a};
                    v  = sx[W-1:0];
                    o  = sx[W] != sx[W-1];
                end else if (fn == 2) v = a & b;
                else if (fn == 3) v = a ^ b;
            end
            4'h3: v = c;
            4'h4, 4'h5: v = b + c;
            4'h8, 4'hA: v = b - 64'd8;
            4'h9, 4'hB: v = b + 64'd8;
            4'h2: v = a;
            default: v = '0;
        endcase
        bad = (ic == 4'h6 && int'(fn) > MAXOP)
            || ((ic == 4'h2 || ic == 4'h7) && fn > 4'd6);
        lt = m.sf ^ m.of;
        eq = m.zf;
        case (fn)
            4'd0: cd = 1'b1;
            4'd1: cd = lt || eq;
            4'd2: cd = lt;
            4'd3: cd = eq;
            4'd4: cd = !eq;
            4'd5: cd = !lt;
            4'd6: cd = !lt && !eq;
            default: cd = 1'b0;
        endcase
        if (!(ic == 4'h2 || ic == 4'h7)) cd = 1'b1;
        d = (ic == 4'h2 && !cd) ? 4'hF : de;
        #1;
        chk("fwd_valE", bus.fwd_valE, v);
        chk("fwd_dstE", bus.fwd_dstE, d);
        we = ic == 4'h6 && en && st == 3'd1 && !stl && !bad;
        if (!stl) begin
            if (bub) bubble_model();
            else begin
                m.stat  = (st == 3'd1 && bad) ? 3'd4 : st;
                m.icode = ic;
                m.cnd   = cd;
                m.valE  = v;
                m.valA  = a;
                m.dstE  = d;
                m.dstM  = dm;
            end
        end
        if (we) begin
            m.zf = v == '0;
            m.sf = v[W-1];
            m.of = o;
        end
        q.push_back(m);
    endtask

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return '1;
            4: return 64'($urandom_range(0, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

`ifdef EXEC_MUL_EN
    task automatic mul_run(input int kill_at);
        int  busy;
        logic seen, fin;
        @(negedge clk);
        bus.e_stat = 3'd1;  bus.e_icode = 4'h6; bus.e_ifun = 4'd4;
        bus.e_valA = 64'd7; bus.e_valB = 64'd6; bus.e_valC = '0;
        bus.e_dstE = 4'd5;  bus.e_dstM = 4'hF;  bus.set_cc_en = 1'b1;
        bus.m_stall = 1'b0; bus.m_bubble = 1'b0; bus.e_kill = 1'b0;
        busy = 0;
        seen = 1'b0;
        fin  = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (bus.ex_busy) begin
                busy++;
                seen = 1'b1;
            end else if (seen) fin = 1'b1;
            if (kill_at > 0 && busy == kill_at) bus.e_kill = 1'b1;
        end
        bus.e_kill = 1'b0;
        chk("mul_end", fin, 1'b1);
        if (kill_at > 0) begin
            chk("kill_busy", busy, kill_at);
            chk("kill_M_icode", bus.M_icode, 4'h1);
            chk("kill_M_dstE", bus.M_dstE, 4'hF);
            chk("kill_ZF", bus.ZF, m.zf);
            bubble_model();
        end else begin
            chk("mul_busy_cycles", busy, W);
            chk("mul_fwd_valE", bus.fwd_valE, 64'd42);
            @(posedge clk);
            #1;
            chk("mul_M_valE", bus.M_valE, 64'd42);
            chk("mul_M_icode", bus.M_icode, 4'h6);
            chk("mul_M_dstE", bus.M_dstE, 4'd5);
            chk("mul_ZF", bus.ZF, 1'b0);
            chk("mul_busy_after", bus.ex_busy, 1'b0);
            m.stat = 3'd1; m.icode = 4'h6; m.cnd = 1'b1;
            m.valE = 64'd42; m.valA = 64'd7; m.dstE = 4'd5; m.dstM = 4'hF;
            m.zf = 1'b0; m.sf = 1'b0; m.of = 1'b0;
        end
    endtask
`endif

    initial begin
        logic [3:0] ic, fn;
        rst = 1'b1;
        bus.e_stat = 3'd1;  bus.e_icode = 4'h1; bus.e_ifun = '0;
        bus.e_valC = '0;    bus.e_valA = '0;    bus.e_valB = '0;
        bus.e_dstE = 4'hF;  bus.e_dstM = 4'hF;  bus.set_cc_en = 1'b1;
        bus.m_stall = 1'b0; bus.m_bubble = 1'b0; bus.e_kill = 1'b0;
        reset_model();
        #2;
        chk("rst_M_stat", bus.M_stat, 3'd1);
        chk("rst_M_icode", bus.M_icode, 4'h1);
        chk("rst_M_cnd", bus.M_cnd, 1'b0);
        chk("rst_M_valE", bus.M_valE, '0);
        chk("rst_M_dstE", bus.M_dstE, 4'hF);
        chk("rst_M_dstM", bus.M_dstM, 4'hF);
        chk("rst_ZF", bus.ZF, 1'b1);
        chk("rst_SF", bus.SF, 1'b0);
        chk("rst_OF", bus.OF, 1'b0);
        chk("rst_busy", bus.ex_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        issue(1, 6, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 2, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("addq_valE", bus.M_valE, 64'h8000_0000_0000_0000);
        chk("addq_ZF", bus.ZF, 1'b0);
        chk("addq_SF", bus.SF, 1'b1);
        chk("addq_OF", bus.OF, 1'b1);
        issue(1, 6, 1, 0, 5, 5, 2, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("subq_valE", bus.M_valE, '0);
        chk("subq_ZF", bus.ZF, 1'b1);
        issue(1, 2, 1, 0, 64'h55, 0, 3, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("cmovle_cnd", bus.M_cnd, 1'b1);
        chk("cmovle_dstE", bus.M_dstE, 4'd3);
        issue(1, 2, 6, 0, 64'h55, 0, 3, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("cmovg_cnd", bus.M_cnd, 1'b0);
        chk("cmovg_dstE", bus.M_dstE, 4'hF);
        issue(1, 4'hA, 0, 0, 0, 64'h100, 4, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("pushq_valE", bus.M_valE, 64'hF8);
        issue(1, 4'hB, 0, 0, 0, 64'hF8, 4, 3, 1, 0, 0);
        @(posedge clk); #2;
        chk("popq_valE", bus.M_valE, 64'h100);
        issue(1, 6, 3, 0, 1, 2, 2, 15, 0, 0, 0);
        @(posedge clk); #2;
        chk("xorq_nocc_ZF", bus.ZF, 1'b1);
        issue(1, 6, 0, 0, 9, 9, 6, 15, 1, 1, 1);
        @(posedge clk); #2;
        chk("stall_bub_icode", bus.M_icode, 4'h6);
        chk("stall_bub_valE", bus.M_valE, 64'd3);
        issue(1, 3, 0, 64'h77, 0, 0, 6, 15, 1, 0, 1);
        @(posedge clk); #2;
        chk("bubble_icode", bus.M_icode, 4'h1);
        issue(1, 6, 7, 0, 1, 1, 6, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("badop_stat", bus.M_stat, 3'd4);
`ifndef EXEC_MUL_EN
        issue(1, 6, 4, 0, 7, 6, 6, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("mul_off_stat", bus.M_stat, 3'd4);
        chk("mul_off_ZF", bus.ZF, 1'b1);
        chk("mul_off_busy", bus.ex_busy, 1'b0);
`endif
        issue(2, 6, 0, 0, 1, 1, 6, 15, 1, 0, 0);
        @(posedge clk); #2;
        chk("hlt_pass_stat", bus.M_stat, 3'd2);

        rst = 1'b1;
        #1;
        chk("arst_M_icode", bus.M_icode, 4'h1);
        chk("arst_M_dstE", bus.M_dstE, 4'hF);
        chk("arst_ZF", bus.ZF, 1'b1);
        #1;
        rst = 1'b0;
        reset_model();

        for (int n = 0; n < 400; n++) begin
            ic = 4'($urandom_range(0, 11));
            if (ic == 4'h2 || ic == 4'h6 || ic == 4'h7)
                fn = 4'($urandom_range(0, 7));
            else
                fn = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
            if (ic == 4'h6 && fn == 4'd4) fn = 4'd5;
`endif
            issue(($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
                  ic, fn, rv(), rv(), rv(), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        issue(1, 1, 0, 0, 0, 0, 15, 15, 1, 0, 0);
        @(posedge clk); #2;

`ifdef EXEC_MUL_EN
        mul_run(0);
        mul_run(10);
        issue(1, 1, 0, 0, 0, 0, 15, 15, 1, 0, 0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drain", 64'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
